pwm_meter: RTL and testbench

Square-wave period and duty measurement block, the receive-side counterpart of the DDS/PWM generator. It samples an asynchronous pulse input and measures the period and high time between consecutive rising edges in `clk` cycles. Results use the same units and format as the generator's `period`/`h_time` controls, so a measured value can be written back to the generator unchanged for loopback self-test. Each new measurement is flagged with a one-cycle strobe.

---
 rtl/pwm_meter_if.sv | 23 ++
 rtl/pwm_meter.sv | 189 ++++++++++++++++++
 tb/tb_pwm_meter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_meter_if.sv
// Signal bundle for the square-wave period/duty meter.
// The slave side belongs to pwm_meter; the master side drives the pulse input and the enable.
interface pwm_meter_if #(
    parameter int CNT_W = 16
);
    logic             sig_in;
    logic             meas_en;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] h_time_out;
    logic             meas_valid;
    logic             timeout;
    logic             busy;

    modport master (
        output sig_in, meas_en,
        input  period_out, h_time_out, meas_valid, timeout, busy
    );

    modport slave (
        input  sig_in, meas_en,
        output period_out, h_time_out, meas_valid, timeout, busy
    );
endinterface

// File: rtl/pwm_meter.sv
// Measures period and high time of an asynchronous square wave in clk cycles.
// Define PWM_METER_DEGLITCH_EN to insert a 3-sample agreement filter ahead of the edge detector.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | measurement disabled, counter and capture cleared
// WAIT_RISE | armed, waiting for the first rising edge of a period
// MEAS_HIGH | counting the high phase, fall captures the high time
// MEAS_LOW  | counting the low phase, rise closes the period
module pwm_meter #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic         clk,
    input  logic         rst_n,
    pwm_meter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEAS_HIGH = 2'd2,
        MEAS_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic sync1;
    logic s_sync;
    logic s_prev;
    logic det;
    logic rise;
    logic fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            s_sync <= 1'b0;
        end else begin
            sync1  <= bus.sig_in;
            s_sync <= sync1;
        end
    end

`ifdef PWM_METER_DEGLITCH_EN
    // s_prev doubles as the filter's held output: it only follows s_sync once three samples agree.
    logic [1:0] hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= 2'b00;
        end else begin
            hist <= {hist[0], s_sync};
        end
    end

    assign det = (s_sync == hist[0] && hist[0] == hist[1]) ? s_sync : s_prev;
`else
    assign det = s_sync;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_prev <= 1'b0;
        end else begin
            s_prev <= det;
        end
    end

    assign rise = det & ~s_prev;
    assign fall = ~det & s_prev;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] hcap;
    logic [CNT_W-1:0] hcap_nxt;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] period_nxt;
    logic [CNT_W-1:0] h_time_q;
    logic [CNT_W-1:0] h_time_nxt;
    logic             valid_q;
    logic             valid_nxt;
    logic             to_q;
    logic             to_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             at_limit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            hcap     <= '0;
            period_q <= '0;
            h_time_q <= '0;
            valid_q  <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            hcap     <= hcap_nxt;
            period_q <= period_nxt;
            h_time_q <= h_time_nxt;
            valid_q  <= valid_nxt;
            to_q     <= to_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        hcap_nxt   = hcap;
        period_nxt = period_q;
        h_time_nxt = h_time_q;
        valid_nxt  = 1'b0;
        to_nxt     = to_q;
        // Saturating increment keeps cnt at LIMIT when a fall lands exactly on the limit.
        cnt_inc    = (cnt < LIMIT) ? cnt + ONE : cnt;
        at_limit   = (cnt == LIMIT);

        if (!bus.meas_en) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            hcap_nxt  = '0;
            to_nxt    = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = WAIT_RISE;
                    cnt_nxt   = '0;
                end
                WAIT_RISE: begin
                    if (rise) begin
                        cnt_nxt   = ONE;
                        state_nxt = MEAS_HIGH;
                    end else begin
                        cnt_nxt = '0;
                    end
                end
                MEAS_HIGH: begin
                    if (fall) begin
                        hcap_nxt  = cnt;
                        cnt_nxt   = cnt_inc;
                        state_nxt = MEAS_LOW;
                    end else if (at_limit) begin
                        to_nxt     = 1'b1;
                        period_nxt = '0;
                        h_time_nxt = '0;
                        cnt_nxt    = '0;
                        hcap_nxt   = '0;
                        state_nxt  = WAIT_RISE;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                MEAS_LOW: begin
                    if (rise) begin
                        period_nxt = cnt;
                        h_time_nxt = hcap;
                        valid_nxt  = 1'b1;
                        to_nxt     = 1'b0;
                        cnt_nxt    = ONE;
                        state_nxt  = MEAS_HIGH;
                    end else if (at_limit) begin
                        to_nxt     = 1'b1;
                        period_nxt = '0;
                        h_time_nxt = '0;
                        cnt_nxt    = '0;
                        hcap_nxt   = '0;
                        state_nxt  = WAIT_RISE;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign bus.period_out = period_q;
    assign bus.h_time_out = h_time_q;
    assign bus.meas_valid = valid_q;
    assign bus.timeout    = to_q;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_pwm_meter.sv
// Self-checking bench for pwm_meter: random synchronous waves scored against an edge-time model.
module tb_pwm_meter;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 1000;
`ifdef PWM_METER_DEGLITCH_EN
    localparam int LAT    = 5;
    localparam int MINSEG = 3;
    localparam bit GLITCH_VIS = 1'b0;
`else
    localparam int LAT    = 3;
    localparam int MINSEG = 1;
    localparam bit GLITCH_VIS = 1'b1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    pwm_meter_if #(.CNT_W(CNT_W)) bus ();

    pwm_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    typedef struct {
        int t;
        int per;
        int hi;
    } ev_t;

    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc   = 0;
    ev_t rq[$];
    int  tq[$];
    bit  sess = 1'b0;
    bit  en_model = 1'b0;
    bit  sig_model = 1'b0;
    int  last_r = 0;
    int  last_f = 0;
    bit  exp_to = 1'b0;
    int  exp_per = 0;
    int  exp_hi = 0;
    bit  to_prev = 1'b0;

    task automatic check(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // One clock: observe outputs just after the edge, then advance the timeout deadline model.
    task automatic tick();
        bit exp_v;
        bit exp_t;
        bit to_rise;
        @(posedge clk);
        #1;
        cyc++;
        exp_v = (rq.size() > 0) && (rq[0].t == cyc);
        if (exp_v || bus.meas_valid) begin
            check("meas_valid", int'(bus.meas_valid), int'(exp_v));
            if (exp_v) begin
                if (bus.meas_valid) begin
                    check("period_out", int'(bus.period_out), rq[0].per);
                    check("h_time_out", int'(bus.h_time_out), rq[0].hi);
                    check("timeout_clr", int'(bus.timeout), 0);
                end
                void'(rq.pop_front());
            end
        end
        to_rise = bus.timeout && !to_prev;
        to_prev = bus.timeout;
        exp_t = (tq.size() > 0) && (tq[0] == cyc);
        if (exp_t || to_rise) begin
            check("timeout_rise", int'(to_rise), int'(exp_t));
            if (exp_t) begin
                check("to_period", int'(bus.period_out), 0);
                check("to_h_time", int'(bus.h_time_out), 0);
                check("to_busy", int'(bus.busy), 1);
                void'(tq.pop_front());
            end
        end
        if (sess && (cyc - last_r == TIMEOUT + 1)) begin
            if (!exp_to) tq.push_back(last_r + LAT + TIMEOUT);
            exp_to  = 1'b1;
            exp_per = 0;
            exp_hi  = 0;
            sess    = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // vis=0 marks a transition the deglitch filter is expected to swallow.
    task automatic set_sig(input bit v, input bit vis);
        if (vis && v != sig_model) begin
            if (v) begin
                if (sess && en_model) begin
                    rq.push_back('{cyc + LAT, cyc - last_r, last_f - last_r});
                    exp_to  = 1'b0;
                    exp_per = cyc - last_r;
                    exp_hi  = last_f - last_r;
                end
                if (en_model) begin
                    sess   = 1'b1;
                    last_r = cyc;
                end
            end else begin
                last_f = cyc;
            end
            sig_model = v;
        end
        bus.sig_in = v;
    endtask

    task automatic wave(input int h, input int l);
        set_sig(1'b1, 1'b1);
        idle(h);
        set_sig(1'b0, 1'b1);
        idle(l);
    endtask

    task automatic enable(input bit e);
        bus.meas_en = e;
        en_model    = e;
        if (!e) begin
            sess   = 1'b0;
            exp_to = 1'b0;
        end
    endtask

    initial begin
        bus.sig_in  = 1'b0;
        bus.meas_en = 1'b0;
        #5 rst_n = 1'b0;
        idle(3);
        check("rst_period", int'(bus.period_out), 0);
        check("rst_h_time", int'(bus.h_time_out), 0);
        check("rst_valid", int'(bus.meas_valid), 0);
        check("rst_timeout", int'(bus.timeout), 0);
        check("rst_busy", int'(bus.busy), 0);
        rst_n = 1'b1;
        idle(3);

        enable(1'b1);
        idle(6);
        check("busy_en", int'(bus.busy), 1);
        repeat (4) wave(25, 75);
        for (int i = 0; i < 15; i++) begin
            wave(int'($urandom_range(300, MINSEG)), int'($urandom_range(300, MINSEG)));
        end
        wave(250, 750);
        wave(25, 75);
        repeat (3) wave(MINSEG, MINSEG);
        repeat (2) wave(25, 75);

        // Disable in the middle of a low phase: outputs hold, no strobe.
        set_sig(1'b1, 1'b1);
        idle(25);
        set_sig(1'b0, 1'b1);
        idle(30);
        enable(1'b0);
        idle(2);
        check("dis_busy", int'(bus.busy), 0);
        check("dis_period", int'(bus.period_out), exp_per);
        check("dis_h_time", int'(bus.h_time_out), exp_hi);
        check("dis_timeout", int'(bus.timeout), 0);
        idle(40);
        enable(1'b1);
        idle(6);
        repeat (3) wave(40, 60);

        // Stuck high, then stuck low, each past the limit.
        set_sig(1'b1, 1'b1);
        idle(TIMEOUT + 100);
        check("dc_hi_timeout", int'(bus.timeout), 1);
        check("dc_hi_busy", int'(bus.busy), 1);
        set_sig(1'b0, 1'b1);
        idle(10);
        repeat (3) wave(50, 150);
        check("restart_timeout", int'(bus.timeout), 0);
        check("restart_period", int'(bus.period_out), 200);
        set_sig(1'b1, 1'b1);
        idle(50);
        set_sig(1'b0, 1'b1);
        idle(TIMEOUT + 50);
        check("dc_lo_timeout", int'(bus.timeout), 1);
        check("dc_lo_h_time", int'(bus.h_time_out), 0);
        repeat (3) wave(25, 75);

        // Short low glitch inside a 25-cycle high phase.
        set_sig(1'b1, 1'b1);
        idle(10);
        set_sig(1'b0, GLITCH_VIS);
        idle(1);
        set_sig(1'b1, GLITCH_VIS);
        idle(14);
        set_sig(1'b0, 1'b1);
        idle(75);
        repeat (3) wave(25, 75);

        // Reset in the middle of a high phase.
        set_sig(1'b1, 1'b1);
        idle(10);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_period", int'(bus.period_out), 0);
        check("mid_rst_h_time", int'(bus.h_time_out), 0);
        check("mid_rst_valid", int'(bus.meas_valid), 0);
        check("mid_rst_busy", int'(bus.busy), 0);
        rq.delete();
        tq.delete();
        sess       = 1'b0;
        exp_to     = 1'b0;
        bus.sig_in = 1'b0;
        sig_model  = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(8);
        for (int i = 0; i < 5; i++) begin
            wave(int'($urandom_range(200, MINSEG)), int'($urandom_range(200, MINSEG)));
        end

        idle(LAT + 5);
        check("results_left", rq.size(), 0);
        check("timeouts_left", tq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
